// File: rtl/mul_issue_ctrl.sv
// Issue/format front-end for the pipelined 64x64 multiplier serving RV64M MUL*.
// Decodes the request, drives the multiplier, formats its product, and keeps a one-entry product cache.
module mul_issue_ctrl #(
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1,
  parameter int TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       funct3_i,
  input  logic             word_i,
  input  logic [63:0]      rs1_i,
  input  logic [63:0]      rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [63:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             resp_err_o,
  output logic             mul_req_valid_o,
  output logic             mul_block_o,
  output logic [63:0]      mul_op_1_o,
  output logic [63:0]      mul_op_2_o,
  output logic             mul_sign_op_1_o,
  output logic             mul_sign_op_2_o,
  input  logic [63:0]      mul_result_l_i,
  input  logic [63:0]      mul_result_h_i,
  input  logic             mul_ready_i,
  input  logic             mul_valid_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [63:0]        op1_reg, op2_reg;
  logic               sign1_reg, sign2_reg;
  logic               high_reg, word_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [63:0]        data_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               cache_valid_reg;
  logic [63:0]        key_op1_reg, key_op2_reg;
  logic               key_sign1_reg, key_sign2_reg;
  logic [127:0]       cache_prod_reg;

  logic               is_illegal, is_word, is_high;
  logic               f_sign1, f_sign2;
  logic [63:0]        f_op1, f_op2;
  logic               ops_match, signs_match, cache_hit;
  logic [63:0]        hit_data, res_data;
  logic               accept, mul_done, timeout_hit;
  logic               unused_mul_ready;

  // The multiplier's ready is not needed: issue is paced purely by our state.
  assign unused_mul_ready = mul_ready_i;

  assign is_illegal = funct3_i[2];
  assign is_word    = (funct3_i == 3'b000) && word_i;
  assign is_high    = (funct3_i != 3'b000);
  assign f_sign1    = (funct3_i != 3'b011);
  assign f_sign2    = (funct3_i == 3'b000) || (funct3_i == 3'b001);
  assign f_op1      = is_word ? {{32{rs1_i[31]}}, rs1_i[31:0]} : rs1_i;
  assign f_op2      = is_word ? {{32{rs2_i[31]}}, rs2_i[31:0]} : rs2_i;

  // A low-half MUL hits on operands alone; the low 64 bits do not depend on signedness.
  assign ops_match   = (f_op1 == key_op1_reg) && (f_op2 == key_op2_reg);
  assign signs_match = (f_sign1 == key_sign1_reg) && (f_sign2 == key_sign2_reg);
  assign cache_hit   = CACHE_EN && cache_valid_reg && !is_illegal && ops_match &&
                       (is_high ? signs_match : !is_word);
  assign hit_data    = is_high ? cache_prod_reg[127:64] : cache_prod_reg[63:0];

  assign res_data = word_reg ? {{32{mul_result_l_i[31]}}, mul_result_l_i[31:0]} :
                    high_reg ? mul_result_h_i : mul_result_l_i;

  assign accept      = req_valid_i && (state_reg == IDLE);
  assign mul_done    = (state_reg == WAIT) && !flush_i && mul_valid_i;
  assign timeout_hit = (state_reg == WAIT) && !flush_i && !mul_valid_i &&
                       (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (is_illegal || cache_hit) ? RESP : ISSUE;
      ISSUE:   state_next = flush_i ? IDLE : WAIT;
      WAIT: begin
        if (flush_i)                         state_next = IDLE;
        else if (mul_valid_i || timeout_hit) state_next = RESP;
      end
      RESP:    if (flush_i || resp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready_o     = (state_reg == IDLE);
  assign resp_valid_o    = (state_reg == RESP);
  assign resp_data_o     = data_reg;
  assign resp_tag_o      = tag_reg;
  assign resp_err_o      = err_reg;
  assign mul_req_valid_o = (state_reg == ISSUE);
  assign mul_block_o     = (((state_reg == ISSUE) || (state_reg == WAIT)) && flush_i) || timeout_hit;
  assign mul_op_1_o      = op1_reg;
  assign mul_op_2_o      = op2_reg;
  assign mul_sign_op_1_o = sign1_reg;
  assign mul_sign_op_2_o = sign2_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      op1_reg         <= '0;
      op2_reg         <= '0;
      sign1_reg       <= 1'b0;
      sign2_reg       <= 1'b0;
      high_reg        <= 1'b0;
      word_reg        <= 1'b0;
      tag_reg         <= '0;
      data_reg        <= '0;
      err_reg         <= 1'b0;
      cnt_reg         <= '0;
      cache_valid_reg <= 1'b0;
      key_op1_reg     <= '0;
      key_op2_reg     <= '0;
      key_sign1_reg   <= 1'b0;
      key_sign2_reg   <= 1'b0;
      cache_prod_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op1_reg   <= f_op1;
        op2_reg   <= f_op2;
        sign1_reg <= f_sign1;
        sign2_reg <= f_sign2;
        high_reg  <= is_high;
        word_reg  <= is_word;
        tag_reg   <= tag_i;
        data_reg  <= cache_hit ? hit_data : '0;
        err_reg   <= is_illegal;
      end
      if (state_reg == ISSUE)     cnt_reg <= '0;
      else if (state_reg == WAIT) cnt_reg <= cnt_reg + 1'b1;
      // Only a product that actually arrived, unflushed, may refill the cache.
      if (mul_done) begin
        data_reg        <= res_data;
        cache_valid_reg <= 1'b1;
        key_op1_reg     <= op1_reg;
        key_op2_reg     <= op2_reg;
        key_sign1_reg   <= sign1_reg;
        key_sign2_reg   <= sign2_reg;
        cache_prod_reg  <= {mul_result_h_i, mul_result_l_i};
      end
      if (timeout_hit) begin
        data_reg <= '0;
        err_reg  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl with a 9-stage multiplier model and a response scoreboard.
// Scenario tasks check latency and side effects; a response monitor compares against the scoreboard.
module tb_mul_issue_ctrl;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [2:0]       funct3;
  logic             word;
  logic [63:0]      rs1, rs2;
  logic [TAG_W-1:0] tag;
  logic             flush;
  logic             resp_valid, resp_ready;
  logic [63:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             resp_err;
  logic             mul_req_valid, mul_block;
  logic [63:0]      mul_op_1, mul_op_2;
  logic             mul_sign_op_1, mul_sign_op_2;
  logic [63:0]      mul_result_l, mul_result_h;
  logic             mul_ready, mul_valid;
  logic             mul_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sq[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TAG_W(TAG_W), .CACHE_EN(1'b1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct3_i(funct3), .word_i(word), .rs1_i(rs1), .rs2_i(rs2), .tag_i(tag),
    .flush_i(flush),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_tag_o(resp_tag), .resp_err_o(resp_err),
    .mul_req_valid_o(mul_req_valid), .mul_block_o(mul_block),
    .mul_op_1_o(mul_op_1), .mul_op_2_o(mul_op_2),
    .mul_sign_op_1_o(mul_sign_op_1), .mul_sign_op_2_o(mul_sign_op_2),
    .mul_result_l_i(mul_result_l), .mul_result_h_i(mul_result_h),
    .mul_ready_i(mul_ready), .mul_valid_i(mul_valid)
  );

  // Multiplier model: 9 pipeline stages, block or reset kills everything in flight.
  logic [8:0]   pv;
  logic [127:0] pp [0:8];

  function automatic logic [127:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                             input logic sa, input logic sb);
    logic [127:0] xa, xb;
    xa = {{64{sa & a[63]}}, a};
    xb = {{64{sb & b[63]}}, b};
    return xa * xb;
  endfunction

  always @(posedge clk) begin
    if (rst || mul_block) begin
      pv <= '0;
    end else begin
      pv    <= {pv[7:0], mul_req_valid};
      pp[0] <= mul_model(mul_op_1, mul_op_2, mul_sign_op_1, mul_sign_op_2);
      for (int i = 1; i < 9; i++) pp[i] <= pp[i-1];
    end
  end

  assign mul_valid    = pv[8] & mul_en;
  assign mul_result_l = pp[8][63:0];
  assign mul_result_h = pp[8][127:64];
  assign mul_ready    = 1'b1;

  // Architectural reference for RV64M results.
  function automatic logic [63:0] ref_result(input logic [2:0] f3, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ua, ub, sa, sb, p;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ref_result = '0;
    case (f3)
      3'b000: begin p = ua * ub; ref_result = w ? {{32{p[31]}}, p[31:0]} : p[63:0]; end
      3'b001: begin p = sa * sb; ref_result = p[127:64]; end
      3'b010: begin p = sa * ub; ref_result = p[127:64]; end
      3'b011: begin p = ua * ub; ref_result = p[127:64]; end
      default: ref_result = '0;
    endcase
  endfunction

  // Response monitor: every handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got data=%h tag=%0d err=%b, want no response",
                 resp_data, resp_tag, resp_err);
      end else begin
        mon_e = sq.pop_front();
        if (resp_data !== mon_e.data || resp_tag !== mon_e.tag || resp_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp_compare: got data=%h tag=%0d err=%b, want data=%h tag=%0d err=%b",
                   resp_data, resp_tag, resp_err, mon_e.data, mon_e.tag, mon_e.err);
        end else begin
          $display("txn tag=%0d data=%h err=%b", resp_tag, resp_data, resp_err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request for one cycle; called at posedge+1 with the DUT idle.
  task automatic send_req(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [TAG_W-1:0] t,
                          input bit expect_err, input bit push);
    exp_t e;
    req_valid = 1'b1;
    funct3    = f3;
    word      = w;
    rs1       = a;
    rs2       = b;
    tag       = t;
    e.tag  = t;
    e.err  = expect_err || f3[2];
    e.data = e.err ? 64'd0 : ref_result(f3, w, a, b);
    if (push) sq.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until resp_valid, plus issue/block activity seen meanwhile.
  task automatic wait_resp(output int lat, output bit got, output int pulses, output int blocks);
    lat = 1; got = 1'b0; pulses = 0; blocks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pulses += int'(mul_req_valid);
      blocks += int'(mul_block);
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, want 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 64'd0 || resp_tag !== '0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: got valid=%b data=%h tag=%0d err=%b, want all 0",
               resp_valid, resp_data, resp_tag, resp_err);
    end
    checks++;
    if (mul_req_valid !== 1'b0 || mul_block !== 1'b0 || mul_op_1 !== 64'd0 || mul_op_2 !== 64'd0 ||
        mul_sign_op_1 !== 1'b0 || mul_sign_op_2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mul_if: got req=%b blk=%b op1=%h op2=%h s=%b%b, want all 0",
               mul_req_valid, mul_block, mul_op_1, mul_op_2, mul_sign_op_1, mul_sign_op_2);
    end
    step();
  endtask

  task automatic test_cache_hit();
    int lat, p, b;
    bit got;
    send_req(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 11) begin errors++; $display("FAIL mulhu_latency: got %0d (seen %b), want 11", lat, got); end
    checks++;
    if (p != 1) begin errors++; $display("FAIL mulhu_issue_pulses: got %0d, want 1", p); end
    step();
    send_req(3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 1) begin errors++; $display("FAIL hit_latency: got %0d (seen %b), want 1", lat, got); end
    checks++;
    if (p != 0) begin errors++; $display("FAIL hit_issue_pulses: got %0d, want 0", p); end
    step();
  endtask

  task automatic test_signed_ops();
    logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b000, 3'b000};
    logic        ws  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] as  [4] = '{-64'sd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'h4000_0000};
    logic [63:0] bs  [4] = '{64'd5, 64'd2, 64'd2, 64'd2};
    int lat, p, b;
    bit got;
    for (int i = 0; i < 4; i++) begin
      send_req(f3s[i], ws[i], as[i], bs[i], 5'(3 + i), 1'b0, 1'b1);
      wait_resp(lat, got, p, b);
      checks++;
      if (!got || lat != 11 || p != 1) begin
        errors++;
        $display("FAIL op%0d_latency: got lat=%0d pulses=%0d (seen %b), want lat=11 pulses=1", i, lat, p, got);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    int lat, p, b;
    bit got;
    send_req(3'b101, 1'b0, 64'd7, 64'd9, 5'd10, 1'b1, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 1 || p != 0) begin
      errors++;
      $display("FAIL illegal_latency: got lat=%0d pulses=%0d (seen %b), want lat=1 pulses=0", lat, p, got);
    end
    step();
  endtask

  task automatic test_timeout();
    int lat, p, b;
    bit got;
    mul_en = 1'b0;
    send_req(3'b011, 1'b0, 64'h1111, 64'h2222, 5'd11, 1'b1, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 17) begin errors++; $display("FAIL timeout_latency: got %0d (seen %b), want 17", lat, got); end
    checks++;
    if (b != 1) begin errors++; $display("FAIL timeout_block_pulses: got %0d, want 1", b); end
    step();
    mul_en = 1'b1;
  endtask

  task automatic test_flush();
    int lat, p, b;
    bit got;
    send_req(3'b000, 1'b0, 64'h5555, 64'h3, 5'd12, 1'b0, 1'b0);
    repeat (4) step();
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (mul_block !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_block: got block=%b resp_valid=%b, want block=1 resp_valid=0", mul_block, resp_valid);
    end
    step();
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got req_ready=%b resp_valid=%b, want 1/0", req_ready, resp_valid);
    end
    step();
    send_req(3'b000, 1'b0, 64'h5555, 64'h3, 5'd13, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 11 || p != 1) begin
      errors++;
      $display("FAIL flush_repeat_miss: got lat=%0d pulses=%0d (seen %b), want lat=11 pulses=1", lat, p, got);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat, p, b;
    bit got;
    logic [63:0] exp_d;
    exp_d = ref_result(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h10);
    resp_ready = 1'b0;
    send_req(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h10, 5'd14, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 11) begin errors++; $display("FAIL bp_latency: got %0d (seen %b), want 11", lat, got); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_tag !== 5'd14 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h tag=%0d ready=%b, want 1 %h 14 0",
                 i, resp_valid, resp_data, resp_tag, req_ready, exp_d);
      end
    end
    step();
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got resp_valid=%b req_ready=%b, want 0/1", resp_valid, req_ready);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, p, b;
    bit got;
    send_req(3'b000, 1'b0, 64'hABCD, 64'h77, 5'd15, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 11) begin errors++; $display("FAIL prefill_latency: got %0d (seen %b), want 11", lat, got); end
    step();
    send_req(3'b011, 1'b0, 64'h9999, 64'h8888, 5'd16, 1'b0, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mul_req_valid !== 1'b0 || mul_block !== 1'b0 ||
        resp_data !== 64'd0 || resp_tag !== '0 || mul_op_1 !== 64'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b rv=%b mrv=%b blk=%b data=%h tag=%0d op1=%h, want reset values",
               req_ready, resp_valid, mul_req_valid, mul_block, resp_data, resp_tag, mul_op_1);
    end
    step();
    send_req(3'b000, 1'b0, 64'hABCD, 64'h77, 5'd17, 1'b0, 1'b1);
    wait_resp(lat, got, p, b);
    checks++;
    if (!got || lat != 11 || p != 1) begin
      errors++;
      $display("FAIL midreset_cache_miss: got lat=%0d pulses=%0d (seen %b), want lat=11 pulses=1", lat, p, got);
    end
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    funct3     = 3'b000;
    word       = 1'b0;
    rs1        = '0;
    rs2        = '0;
    tag        = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    mul_en     = 1'b1;
    #1;
    test_reset();
    test_cache_hit();
    test_signed_ops();
    test_illegal();
    test_timeout();
    test_flush();
    test_backpressure();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
